const_div_seq: RTL and testbench

CONST_DIV_SEQ -- requirements
Module: const_div_seq

---
 rtl/const_div_seq.sv | 94 +++++++++
 tb/tb_const_div_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/const_div_seq.sv
// const_div_seq: sequential divide-by-constant, K dividend bits per cycle
// through a constant quotient/residue lookup, with valid/ready handshakes.
module const_div_seq #(
  parameter int N = 32,
  parameter int D = 23,
  parameter int K = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_q,
  output logic [$clog2(D)-1:0]   out_r,
  output logic                   busy
);
  localparam int RW = $clog2(D);
  localparam int STEPS = N / K;
  localparam int TW = RW + K;
  localparam int CW = $clog2(STEPS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] sh_q, sh_d, acc_q, acc_d, quo_q, quo_d;
  logic [RW-1:0] r_q, r_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] t;
  logic [K-1:0] q_tab [2**TW];
  logic [RW-1:0] r_tab [2**TW];
  // Constant tables evaluated at elaboration; only t < D*2^K is ever indexed.
  for (genvar i = 0; i < 2**TW; i++) begin : g_tab
    localparam int unsigned QV = i / D;
    localparam int unsigned RV = i % D;
    assign q_tab[i] = QV[K-1:0];
    assign r_tab[i] = RV[RW-1:0];
  end
  assign t = {r_q, sh_q[N-1 -: K]};
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    acc_d = acc_q;
    r_d = r_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sh_d = in_x;
        acc_d = '0;
        r_d = '0;
        cnt_d = CW'(STEPS);
        state_d = RUN;
      end
      RUN: begin
        r_d = r_tab[t];
        acc_d = (acc_q << K) | N'(q_tab[t]);
        sh_d = sh_q << K;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d = acc_d;
          rem_d = r_d;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q <= '0;
      acc_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      acc_q <= acc_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q == RUN;
  assign out_q = quo_q;
  assign out_r = rem_q;
endmodule

// File: tb/tb_const_div_seq.sv
// tb_const_div_seq: directed and random checks of const_div_seq with a
// default (32/23/2) instance and a (24/7/3) instance.
module tb_const_div_seq;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 1, in_ready, out_valid, busy;
  logic [31:0] in_x = 0, out_q;
  logic [4:0] out_r;
  logic b_in_valid = 0, b_out_ready = 1, b_in_ready, b_out_valid, b_busy;
  logic [23:0] b_in_x = 0, b_out_q;
  logic [2:0] b_out_r;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [31:0] q; logic [4:0] r; } res_t;
  res_t sb[$];
  res_t e;
  always #5 clk = ~clk;
  const_div_seq u_dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .busy(busy));
  const_div_seq #(.N(24), .D(7), .K(3)) u_b (.clk(clk), .rst_n(rst_n), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_x(b_in_x), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_q(b_out_q), .out_r(b_out_r), .busy(b_busy));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [31:0] x, input bit hold);
    int lat = 0, nb = 0, bad = 0;
    while (!in_ready && lat < 50) begin step(); lat++; end
    chk("ready_wait", in_ready, 1);
    out_ready = !hold;
    in_valid = 1;
    in_x = x;
    sb.push_back('{x / 23, 5'(x % 23)});
    step();
    in_valid = 0;
    in_x = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      nb += int'(busy);
      bad += int'(in_ready);
      in_valid = $urandom_range(0, 1);
      step();
      lat++;
    end
    in_valid = 0;
    chk("latency", lat, 16);
    chk("busy_cycles", nb, 16);
    chk("in_ready_run", bad, 0);
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("q", out_q, e.q);
    chk("r", out_r, e.r);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = i[0];
        in_x = $urandom;
        step();
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
        chk("hold_q", out_q, e.q);
        chk("hold_r", out_r, e.r);
      end
      in_valid = 0;
      out_ready = 1;
    end
    step();
    chk("handshake_valid", out_valid, 0);
    chk("handshake_ready", in_ready, 1);
    out_ready = 1;
  endtask
  task automatic run_b(input logic [23:0] x);
    int lat = 0;
    b_in_valid = 1;
    b_in_x = x;
    step();
    b_in_valid = 0;
    while (!b_out_valid && lat < 100) begin step(); lat++; end
    chk("b_latency", lat, 8);
    chk("b_q", b_out_q, x / 7);
    chk("b_r", b_out_r, x % 7);
    step();
    chk("b_ready", b_in_ready, 1);
  endtask
  initial begin
    step();
    step();
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", out_q, 0);
    chk("rst_r", out_r, 0);
    rst_n = 1;
    step();
    run(32'd1000, 0);
    chk("q_1000", out_q, 43);
    chk("r_1000", out_r, 11);
    run(32'hFFFF_FFFF, 0);
    chk("q_max", out_q, 32'h0B21642C);
    chk("r_max", out_r, 11);
    run(32'd0, 0);
    run(32'd22, 0);
    run(32'd23, 0);
    run(32'd12345678, 1);
    in_valid = 1;
    in_x = 32'd999;
    step();
    in_valid = 0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_busy", busy, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("abort_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_q", out_q, 0);
    chk("abort_r", out_r, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin seen += int'(out_valid); step(); end
      chk("abort_no_valid", seen, 0);
    end
    run(32'd46, 0);
    chk("q_46", out_q, 2);
    chk("r_46", out_r, 0);
    for (int i = 0; i < 150; i++) run($urandom, i % 37 == 0);
    run_b(24'd0);
    run_b(24'hFFFFFF);
    for (int i = 0; i < 150; i++) run_b(24'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
